i2s_deserializer: RTL and testbench
===================================

# i2s_deserializer

Converts the synchronized I2S serial stream (sck, sck_transition, sd, ws) from the i2s_in synchronizer into parallel stereo sample pairs in the system clock domain. It sits directly downstream of the synchronizer. It aligns to the I2S frame and shifts in MSB-first data on sck rising edges. It presents one left/right word pair per frame with a single-cycle valid strobe.

## Interface
- WIDTH, 16, bits per channel word delivered on the parallel outputs
- CNT_W, 5, bit-counter width; must hold WIDTH+1 (5 for WIDTH=16)

- clk  input  1  system clock (100 MHz)
- rst_n  input  1  reset, asynchronous, active-low
- sck  input  1  synchronized serial clock level
- sck_transition  input  1  one-clk pulse on any synchronized sck edge; rising edge = sck_transition & sck
- sd  input  1  synchronized serial data
- ws  input  1  synchronized word select (0 = left, 1 = right)
- left_data  output  WIDTH  last complete left word
- right_data  output  WIDTH  last complete right word
- frame_valid  output  1  one-clk pulse when a new left/right pair is loaded
- locked  output  1  high once frame alignment is acquired
- framing_err  output  1  sticky word-length error (see Configuration)

## Operation
- Sample strobe: `rise = sck_transition & sck`. All state below changes only on clk edges where rise=1, except the frame_valid clear.
- On each rise:
  - Register ws_d <= ws.
  - A ws edge is ws != ws_d. It marks the bit sampled on this rise as the LSB of the word on channel ws_d. The next bit is the MSB of the other channel (standard I2S one-bit delay).
- FSM states:
  - SYNC: shifting is ignored. On a rise with ws_d=1 and ws=0 (end of a right word), go to RUN, clear shift register and bit counter. locked=0.
  - RUN: locked=1. On each rise, if bit_cnt < WIDTH, write sd into shift[WIDTH-1-bit_cnt]. Bits beyond WIDTH are discarded, so the word is truncated and MSB-justified. bit_cnt increments and saturates at WIDTH+1.
- Word completion in RUN, on a rise with ws edge, after including the current bit:
  - ws_d=0: left word done; latch it into an internal left_hold.
  - ws_d=1: right word done; left_data <= left_hold, right_data <= assembled word, frame_valid pulses.
  - In both cases, clear shift register and bit_cnt for the next word.
- Short words (fewer than WIDTH bits) are zero-filled in the LSBs.
- ws_d reset value is 0. After reset, the first output pair is the first complete left+right frame following a right-to-left boundary.

## Timing
- Reset values: left_data=0, right_data=0, frame_valid=0, locked=0, framing_err=0, state=SYNC, ws_d=0, shift=0, bit_cnt=0.
- Outputs are registered at the clk edge where rise and the right-LSB condition coincide. They are visible the following cycle.
- frame_valid is high for exactly one clk, then returns to 0. left_data and right_data hold until the next frame.
- The locked rising edge occurs one clk after the sampling edge of the first 1→0 ws transition.
- A sck_transition with sck=0 (falling edge) has no effect.
- Reset asserted mid-frame clears everything immediately and returns to SYNC. The partial frame is dropped.
- Minimum spacing between rise strobes is 2 clk. Behaviour is undefined for faster sck.

## Configuration
- I2S_DESER_ERR_EN defined:
  - On every word completion in RUN, the completed word's bit count (bit_cnt+1) is checked. If it is not equal to WIDTH, framing_err is set.
  - framing_err is sticky and is cleared only by reset.
- Undefined: framing_err is tied to 0 and no length-compare logic is built.
- Data path behaviour is identical either way.

## Test plan
- Reset release with 16-bit frames (L,R) = (AAAA,FFFF), (1478,A3B9), (CDD7,BABA); half-sck = 40 clk:
  - First frame is consumed for sync.
  - frame_valid pulses twice, with pairs (1478,A3B9) then (CDD7,BABA).
  - locked=1 after the end of the first right word; framing_err=0.
- 11-frame sequence ending (69D9,ABCD):
  - Exactly 10 frame_valid pulses, each 1 clk wide.
  - Final outputs hold 69D9/ABCD indefinitely after sck stops.
- 18-bit words with MSBs matching 16'hF8D5 / 16'hD55A:
  - Outputs are F8D5/D55A (extra LSBs dropped).
  - With I2S_DESER_ERR_EN, framing_err=1.
- 12-bit words 0xABC / 0x123:
  - Outputs are ABC0/1230.
  - With I2S_DESER_ERR_EN, framing_err=1; without it, framing_err=0.
- rst_n pulsed low mid right word of frame 2:
  - All outputs return to 0 asynchronously.
  - After release, locked=0 until the next 1→0 ws transition, and the first valid pair is the next full frame.
- sck_transition pulses with sck=0 only (no rising edges):
  - Shift register, outputs and FSM state are unchanged; frame_valid stays 0.

Source files
------------

// File: rtl/i2s_deserializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2s_deserializer
// Purpose  : Turns a synchronized I2S stream into left/right parallel word pairs.
//            Optional word-length checking is built when I2S_DESER_ERR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_deserializer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sck,
  input  logic             sck_transition,
  input  logic             sd,
  input  logic             ws,
  output logic [WIDTH-1:0] left_data,
  output logic [WIDTH-1:0] right_data,
  output logic             frame_valid,
  output logic             locked,
  output logic             framing_err
);

  localparam logic [0:0]       c_st_sync  = 1'b0;
  localparam logic [0:0]       c_st_run   = 1'b1;
  localparam logic [CNT_W-1:0] c_width    = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] c_width_m1 = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_sat  = CNT_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);

  logic [0:0]       r_state;
  logic [0:0]       w_next_state;
  logic             r_ws_d;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_left_hold;
  logic [WIDTH-1:0] r_left_data;
  logic [WIDTH-1:0] r_right_data;
  logic             r_frame_valid;
  logic             w_rise;
  logic             w_ws_edge;
  logic [CNT_W-1:0] w_idx;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_word;

  assign w_rise    = sck_transition & sck;
  assign w_ws_edge = ws != r_ws_d;

  // Current word including the bit sampled on this rise; bits past WIDTH are dropped.
  always_comb begin
    w_idx  = c_width_m1 - r_bit_cnt;
    w_mask = '0;
    if (r_bit_cnt < c_width)
      w_mask = c_one << w_idx;
    w_word = sd ? (r_shift | w_mask) : r_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= c_st_sync;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (r_state == c_st_sync && w_rise && r_ws_d && !ws)
      w_next_state = c_st_run;
  end

  always_comb begin
    locked = (r_state == c_st_run);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ws_d        <= 1'b0;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_left_hold   <= '0;
      r_left_data   <= '0;
      r_right_data  <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      if (w_rise) begin
        r_ws_d <= ws;
        if (r_state == c_st_sync) begin
          r_shift   <= '0;
          r_bit_cnt <= '0;
        end else if (w_ws_edge) begin
          // A ws edge marks the LSB of the channel that was active (r_ws_d).
          if (r_ws_d) begin
            r_left_data   <= r_left_hold;
            r_right_data  <= w_word;
            r_frame_valid <= 1'b1;
          end else begin
            r_left_hold <= w_word;
          end
          r_shift   <= '0;
          r_bit_cnt <= '0;
        end else begin
          r_shift <= w_word;
          if (r_bit_cnt != c_cnt_sat)
            r_bit_cnt <= r_bit_cnt + c_cnt_one;
        end
      end
    end
  end

`ifdef I2S_DESER_ERR_EN
  logic r_framing_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_framing_err <= 1'b0;
    else if (w_rise && r_state == c_st_run && w_ws_edge && r_bit_cnt != c_width_m1)
      r_framing_err <= 1'b1;
  end

  assign framing_err = r_framing_err;
`else
  assign framing_err = 1'b0;
`endif

  assign left_data   = r_left_data;
  assign right_data  = r_right_data;
  assign frame_valid = r_frame_valid;

endmodule
`default_nettype wire

// File: tb/tb_i2s_deserializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2s_deserializer
// Purpose  : Scoreboard bench driving I2S frames into i2s_deserializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        sck_transition = 1'b0;
  logic        sd = 1'b0;
  logic        ws = 1'b0;
  logic [15:0] left_data;
  logic [15:0] right_data;
  logic        frame_valid;
  logic        locked;
  logic        framing_err;

  int          n_vec = 0;
  int          n_miss = 0;
  int          half = 40;
  logic [31:0] exp_q[$];

`ifdef I2S_DESER_ERR_EN
  localparam logic c_err = 1'b1;
`else
  localparam logic c_err = 1'b0;
`endif

  i2s_deserializer #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .sck_transition(sck_transition),
    .sd(sd), .ws(ws), .left_data(left_data), .right_data(right_data),
    .frame_valid(frame_valid), .locked(locked), .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every frame_valid cycle must match the next queued pair.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && frame_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame_valid", {left_data, right_data}, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        check("left_data", {16'h0, left_data}, {16'h0, e[31:16]});
        check("right_data", {16'h0, right_data}, {16'h0, e[15:0]});
      end
    end
  end

  task automatic send_bit(input logic b, input logic w);
    @(negedge clk);
    sd = b; ws = w; sck = 1'b1; sck_transition = 1'b1;
    @(negedge clk);
    sck_transition = 1'b0;
    repeat (half - 1) @(negedge clk);
    sck = 1'b0; sck_transition = 1'b1;
    @(negedge clk);
    sck_transition = 1'b0;
    repeat (half - 2) @(negedge clk);
  endtask

  // ws flips on the LSB so the next word's MSB follows one bit later.
  task automatic send_word(input logic [31:0] w, input int nbits, input logic ch);
    for (int i = nbits - 1; i >= 0; i--)
      send_bit(w[i], (i == 0) ? ~ch : ch);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nbits);
    send_word(l, nbits, 1'b0);
    send_word(r, nbits, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; sck = 1'b0; sck_transition = 1'b0; sd = 1'b0; ws = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic queue_empty(string name);
    check(name, exp_q.size(), 0);
  endtask

  logic [31:0] t2 [11] = '{32'h0F0F_F0F0, 32'h1234_5678, 32'h8001_7FFE, 32'hDEAD_BEEF,
                           32'h0000_FFFF, 32'hFFFF_0000, 32'h5555_AAAA, 32'hC3C3_3C3C,
                           32'h0001_8000, 32'h9E37_79B9, 32'h69D9_ABCD};
  logic [31:0] b_right = 32'h0000_F00F;

  initial begin
    do_reset();
    check("rst_left", {16'h0, left_data}, 0);
    check("rst_right", {16'h0, right_data}, 0);
    check("rst_valid", frame_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_err", framing_err, 0);

    // Three 16-bit frames, slow sck; first frame only aligns.
    half = 40;
    send_word(32'hAAAA, 16, 1'b0);
    check("t1_locked_before", locked, 0);
    send_word(32'hFFFF, 16, 1'b1);
    check("t1_locked_after", locked, 1);
    exp_q.push_back(32'h1478_A3B9);
    send_frame(32'h1478, 32'hA3B9, 16);
    exp_q.push_back(32'hCDD7_BABA);
    send_frame(32'hCDD7, 32'hBABA, 16);
    repeat (10) @(negedge clk);
    queue_empty("t1_pairs_seen");
    check("t1_err", framing_err, 0);

    // Eleven frames from reset: ten pairs expected.
    half = 4;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      if (i > 0) exp_q.push_back(t2[i]);
      send_frame({16'h0, t2[i][31:16]}, {16'h0, t2[i][15:0]}, 16);
    end
    repeat (200) @(negedge clk);
    queue_empty("t2_pairs_seen");
    check("t2_hold_left", {16'h0, left_data}, 32'h69D9);
    check("t2_hold_right", {16'h0, right_data}, 32'hABCD);
    check("t2_hold_valid", frame_valid, 0);

    // Falling-edge-only transitions must be ignored.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sd = 1'b1; ws = i[0]; sck_transition = 1'b1;
      @(negedge clk);
      sck_transition = 1'b0;
      repeat (3) @(negedge clk);
    end
    ws = 1'b0; sd = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_left", {16'h0, left_data}, 32'h69D9);
    check("t6_right", {16'h0, right_data}, 32'hABCD);
    check("t6_locked", locked, 1);

    // Reset asserted mid right word of frame B.
    exp_q.push_back(32'h1357_2468);
    send_frame(32'h1357, 32'h2468, 16);
    send_word(32'h3C3C, 16, 1'b0);
    for (int i = 15; i >= 8; i--) send_bit(b_right[i], 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_async_left", {16'h0, left_data}, 0);
    check("t5_async_right", {16'h0, right_data}, 0);
    check("t5_async_locked", locked, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_locked_after_rel", locked, 0);
    for (int i = 7; i >= 0; i--) send_bit(b_right[i], (i == 0) ? 1'b0 : 1'b1);
    check("t5_relocked", locked, 1);
    exp_q.push_back(32'h7E81_0102);
    send_frame(32'h7E81, 32'h0102, 16);
    exp_q.push_back(32'hFEDC_0BA9);
    send_frame(32'hFEDC, 32'h0BA9, 16);
    repeat (10) @(negedge clk);
    queue_empty("t5_pairs_seen");
    check("t5_err", framing_err, 0);

    // 18-bit words: extra LSBs dropped.
    exp_q.push_back(32'hF8D5_D55A);
    send_frame(32'h0003_E357, 32'h0003_5569, 18);
    repeat (10) @(negedge clk);
    queue_empty("t3_pairs_seen");
    check("t3_err", framing_err, {31'h0, c_err});

    // 12-bit words: zero-filled LSBs.
    do_reset();
    check("t4_err_cleared", framing_err, 0);
    send_frame(32'h0000_0555, 32'h0000_0AAA, 12);
    exp_q.push_back(32'hABC0_1230);
    send_frame(32'h0000_0ABC, 32'h0000_0123, 12);
    repeat (10) @(negedge clk);
    queue_empty("t4_pairs_seen");
    check("t4_err", framing_err, {31'h0, c_err});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
